// File: rtl/event_queue_n.sv
// event_queue_n -- multi-lane sorted event queue.
//
// Q_NUM lanes, each a LANE_DEPTH-entry shift-register priority queue kept
// sorted by the TIME field EV_in[HI:LO] (unsigned). An insert goes to the
// least-occupied non-full lane (ties go to the lowest index) and lands behind
// every valid entry with an equal or smaller TIME. EV_out/dv register the
// smallest lane head every cycle. An extract removes the head of the lane that
// sourced EV_out.
//
// Optional build macro EQ_HWM_EN adds the hwm port: the largest length seen
// since reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   EV_in        entry to insert
//   op           `INSERT_CMD / `EXTRACT_CMD
//   cs           command strobe, at most one command per cycle
//   EV_out       registered minimum-TIME entry
//   dv           EV_out valid
//   full/empty   length at capacity / zero
//   busy_for_rd  EV_out is refreshing this cycle, so an extract is refused
//   busy_for_wr  same as full
//   length       total stored entries
//   ovf/udf      sticky rejected-insert / rejected-extract flags
//   hwm          (EQ_HWM_EN only) maximum length since reset

`ifndef INSERT_CMD
`define INSERT_CMD 1'b1
`endif
`ifndef EXTRACT_CMD
`define EXTRACT_CMD 1'b0
`endif

module event_queue_n #(
  parameter int DATA_WD    = 32,
  parameter int HI         = 15,
  parameter int LO         = 0,
  parameter int Q_NUM      = 4,
  parameter int LANE_DEPTH = 8,
  parameter int LEN_WD     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_WD-1:0] EV_in,
  input  logic               op,
  input  logic               cs,
  output logic [DATA_WD-1:0] EV_out,
  output logic               dv,
  output logic               full,
  output logic               empty,
  output logic               busy_for_rd,
  output logic               busy_for_wr,
  output logic [LEN_WD-1:0]  length,
  output logic               ovf,
  output logic               udf
`ifdef EQ_HWM_EN
  ,
  output logic [LEN_WD-1:0]  hwm
`endif
);

  localparam int TOTAL = Q_NUM * LANE_DEPTH;
  localparam int OW    = $clog2(LANE_DEPTH + 1);
  localparam int LW    = $clog2(Q_NUM);
  localparam int TW    = HI - LO + 1;

  logic [DATA_WD-1:0] cells [Q_NUM][LANE_DEPTH];
  logic [OW-1:0]      occ   [Q_NUM];
  logic [LW-1:0]      src_lane;

  logic [LW-1:0] ins_lane;
  logic [OW-1:0] best_occ;
  logic [OW-1:0] ins_pos;
  logic          min_found;
  logic [LW-1:0] min_lane;
  logic [TW-1:0] min_time;
  logic          ins_ok;
  logic          ext_ok;

  assign full        = (length == LEN_WD'(TOTAL));
  assign empty       = (length == '0);
  assign busy_for_wr = full;

  assign ins_ok = cs && (op == `INSERT_CMD) && !full;
  assign ext_ok = cs && (op == `EXTRACT_CMD) && dv && !busy_for_rd;

  // Strict less-than keeps the lowest index on ties and never picks a full
  // lane, because best_occ starts at the lane capacity.
  always_comb begin
    ins_lane = '0;
    best_occ = OW'(LANE_DEPTH);
    for (int q = 0; q < Q_NUM; q++) begin
      if (occ[q] < best_occ) begin
        best_occ = occ[q];
        ins_lane = LW'(q);
      end
    end
  end

  // A lane is sorted, so the cells with TIME <= new TIME form a prefix. Its
  // length is the slot the new entry takes.
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < LANE_DEPTH; i++) begin
      if ((OW'(i) < occ[ins_lane]) &&
          (cells[ins_lane][i][HI:LO] <= EV_in[HI:LO]))
        ins_pos = ins_pos + 1'b1;
    end
  end

  always_comb begin
    min_found = 1'b0;
    min_lane  = '0;
    min_time  = '0;
    for (int q = 0; q < Q_NUM; q++) begin
      if ((occ[q] != '0) && (!min_found || (cells[q][0][HI:LO] < min_time))) begin
        min_found = 1'b1;
        min_lane  = LW'(q);
        min_time  = cells[q][0][HI:LO];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < Q_NUM; q++) begin
        occ[q] <= '0;
        for (int i = 0; i < LANE_DEPTH; i++)
          cells[q][i] <= '0;
      end
    end else if (ins_ok) begin
      for (int i = 1; i < LANE_DEPTH; i++)
        if (OW'(i) > ins_pos)
          cells[ins_lane][i] <= cells[ins_lane][i-1];
      for (int i = 0; i < LANE_DEPTH; i++)
        if (OW'(i) == ins_pos)
          cells[ins_lane][i] <= EV_in;
      occ[ins_lane] <= occ[ins_lane] + 1'b1;
    end else if (ext_ok) begin
      for (int i = 0; i < LANE_DEPTH - 1; i++)
        cells[src_lane][i] <= cells[src_lane][i+1];
      occ[src_lane] <= occ[src_lane] - 1'b1;
    end
  end

  // Output stage. Removing the last entry drops dv immediately, instead of
  // showing the stale head for one more cycle. EV_out keeps its last value
  // whenever nothing is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      EV_out   <= '0;
      dv       <= 1'b0;
      src_lane <= '0;
    end else if (ext_ok && (length == LEN_WD'(1))) begin
      dv <= 1'b0;
    end else if (min_found) begin
      EV_out   <= cells[min_lane][0];
      src_lane <= min_lane;
      dv       <= 1'b1;
    end else begin
      dv <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      length      <= '0;
      busy_for_rd <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
    end else begin
      busy_for_rd <= ins_ok || ext_ok;
      if (ins_ok)
        length <= length + LEN_WD'(1);
      else if (ext_ok)
        length <= length - LEN_WD'(1);
      if (cs && (op == `INSERT_CMD) && full)
        ovf <= 1'b1;
      if (cs && (op == `EXTRACT_CMD) && !ext_ok)
        udf <= 1'b1;
    end
  end

`ifdef EQ_HWM_EN
  // Only an insert can raise length, so hwm is compared against length+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hwm <= '0;
    else if (ins_ok && ((length + LEN_WD'(1)) > hwm))
      hwm <= length + LEN_WD'(1);
  end
`else
  // Without EQ_HWM_EN there is no watermark tracking.
`endif

endmodule

// File: tb/tb_event_queue_n.sv
`ifndef INSERT_CMD
`define INSERT_CMD 1'b1
`endif
`ifndef EXTRACT_CMD
`define EXTRACT_CMD 1'b0
`endif

module tb_event_queue_n;
  localparam int QN  = 4;
  localparam int LD  = 8;
  localparam int TOT = QN * LD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ev_in = '0;
  logic        op = 1'b0;
  logic        cs = 1'b0;
  logic [31:0] ev_out;
  logic        dv, full, empty, busy_for_rd, busy_for_wr, ovf, udf;
  logic [5:0]  length;
`ifdef EQ_HWM_EN
  logic [5:0]  hwm;
`endif

  event_queue_n dut (
    .clk(clk), .rst(rst), .EV_in(ev_in), .op(op), .cs(cs),
    .EV_out(ev_out), .dv(dv), .full(full), .empty(empty),
    .busy_for_rd(busy_for_rd), .busy_for_wr(busy_for_wr),
    .length(length), .ovf(ovf), .udf(udf)
`ifdef EQ_HWM_EN
    , .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one sorted queue per lane.
  logic [31:0] mq [QN][$];
  int m_len, m_hwm;
  bit m_busy, m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int q = 0; q < QN; q++) mq[q].delete();
    m_len = 0; m_hwm = 0; m_busy = 0; m_ovf = 0; m_udf = 0;
  endtask

  function automatic logic [31:0] m_head(output int lane);
    logic [31:0] best;
    best = '0;
    lane = -1;
    for (int q = 0; q < QN; q++)
      if (mq[q].size() > 0 && (lane < 0 || mq[q][0][15:0] < best[15:0])) begin
        lane = q;
        best = mq[q][0];
      end
    return best;
  endfunction

  task automatic m_insert(input logic [31:0] e);
    int l, pos;
    l = 0;
    for (int q = 1; q < QN; q++)
      if (mq[q].size() < mq[l].size()) l = q;
    pos = mq[l].size();
    for (int i = 0; i < mq[l].size(); i++)
      if (mq[l][i][15:0] > e[15:0]) begin
        pos = i;
        break;
      end
    mq[l].insert(pos, e);
  endtask

  task automatic check_state();
    int l;
    logic [31:0] h;
    chk("length", 32'(length), 32'(m_len));
    chk("full", 32'(full), 32'(m_len == TOT));
    chk("empty", 32'(empty), 32'(m_len == 0));
    chk("busy_for_rd", 32'(busy_for_rd), 32'(m_busy));
    chk("busy_for_wr", 32'(busy_for_wr), 32'(m_len == TOT));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`ifdef EQ_HWM_EN
    chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
    if (!m_busy || m_len == 0) chk("dv", 32'(dv), 32'(m_len > 0));
    if (!m_busy && m_len > 0) begin
      h = m_head(l);
      chk("ev_out", ev_out, h);
    end
  endtask

  // Called at 1 time unit after a rising edge. Applies a command for one
  // cycle and checks the state after the edge.
  task automatic cycle(input bit c, input bit o, input logic [31:0] e);
    bit acc;
    int l;
    logic [31:0] h;
    acc = 0;
    cs = c; op = o; ev_in = e;
    if (c) begin
      if (o == `INSERT_CMD) begin
        if (m_len < TOT) begin
          m_insert(e);
          m_len++;
          acc = 1;
          if (m_len > m_hwm) m_hwm = m_len;
        end else m_ovf = 1;
      end else begin
        if (!m_busy && m_len > 0) begin
          h = m_head(l);
          chk("extract_data", ev_out, h);
          void'(mq[l].pop_front());
          m_len--;
          acc = 1;
        end else m_udf = 1;
      end
    end
    @(posedge clk); #1;
    cs = 0;
    m_busy = acc;
    check_state();
  endtask

  task automatic ins(input logic [31:0] e); cycle(1, `INSERT_CMD, e); endtask
  task automatic ext(); cycle(1, `EXTRACT_CMD, '0); endtask
  task automatic idle(); cycle(0, 0, '0); endtask

  task automatic drain();
    while (m_len > 0) begin
      ext();
      idle();
    end
  endtask

  task automatic do_reset();
    rst = 0;
    cs = 0;
    m_clear();
    @(posedge clk); #1;
    chk("rst_ev_out", ev_out, 32'h0);
    chk("rst_dv", 32'(dv), 32'h0);
    check_state();
    rst = 1;
    @(posedge clk); #1;
    check_state();
  endtask

  initial begin
    int r;
    m_clear();
    // Reset values
    do_reset();

    // Insert TIME 5,3,9, then read back 3,5,9
    ins({16'hA005, 16'd5});
    ins({16'hA003, 16'd3});
    ins({16'hA009, 16'd9});
    idle();
    chk("min_time_3", 32'(ev_out[15:0]), 32'd3);
    chk("len_3", 32'(length), 32'd3);
    for (int i = 0; i < 3; i++) begin
      ext();
      idle();
    end
    chk("empty_after_drain", 32'(empty), 32'd1);
    chk("dv_after_drain", 32'(dv), 32'd0);

    // One entry per lane, then equal TIMEs A then B come out in insert order
    ins({16'h0001, 16'd10});
    ins({16'h0002, 16'd20});
    ins({16'h0003, 16'd30});
    ins({16'h0004, 16'd40});
    ins({16'hAAAA, 16'd7});
    ins({16'hBBBB, 16'd7});
    idle();
    chk("tie_first_A", ev_out, {16'hAAAA, 16'd7});
    ext();
    idle();
    chk("tie_second_B", ev_out, {16'hBBBB, 16'd7});
    drain();

    // Extract during busy_for_rd is refused and sets udf
    ins({16'h1111, 16'd4});
    ins({16'h2222, 16'd2});
    idle();
    ext();
    ext();
    chk("busy_ext_len", 32'(length), 32'd1);
    chk("busy_ext_udf", 32'(udf), 32'd1);
    idle();
    drain();

    // Fill to capacity, then one more insert
    do_reset();
    for (int i = 0; i < TOT; i++) ins({16'(i), 16'($urandom_range(0, 63))});
    idle();
    chk("fill_full", 32'(full), 32'd1);
    ins(32'h0000_0001);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_len", 32'(length), 32'd32);
    drain();

    // Extract while empty
    do_reset();
    ext();
    chk("udf_empty", 32'(udf), 32'd1);

    // Random mix against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5) ins({16'($urandom), 16'($urandom_range(0, 15))});
      else if (r < 8) ext();
      else idle();
    end
    idle();
    drain();

    // Reset in the middle of an insert with length=10
    do_reset();
    for (int i = 0; i < 10; i++) ins({16'(i), 16'($urandom_range(0, 31))});
    idle();
    chk("pre_rst_len", 32'(length), 32'd10);
    cs = 1; op = `INSERT_CMD; ev_in = 32'h1234_0001;
    #2 rst = 0;
    #1;
    chk("arst_len", 32'(length), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_dv", 32'(dv), 32'd0);
    chk("arst_ev_out", ev_out, 32'h0);
    chk("arst_busy", 32'(busy_for_rd), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_udf", 32'(udf), 32'd0);
`ifdef EQ_HWM_EN
    chk("arst_hwm", 32'(hwm), 32'd0);
`endif
    cs = 0;
    m_clear();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
